// File: rtl/plab4_net_router_input_terminal_arbiter_tdm_pkg.sv
// Shared definitions for the TDM input-terminal arbiter: request bit positions,
// the bubble credit threshold and the domain-index width rule.
package plab4_net_arb_pkg;

   localparam int REQ_WEST      = 0;
   localparam int REQ_TERM      = 1;
   localparam int REQ_EAST      = 2;
   localparam int BUBBLE_CREDIT = 2;

   // A domain index is never narrower than one bit, even for degenerate counts.
   function automatic int dom_nbits(input int num_domains);
      return (num_domains < 2) ? 1 : $clog2(num_domains);
   endfunction

endpackage

// File: rtl/plab4_net_router_input_terminal_arbiter_tdm_route.sv
// Per-domain route computation on a ring: terminal, east (shortest or tie) or
// west, with east/west gated by the downstream bubble credit.
module plab4_net_route_compute
   import plab4_net_arb_pkg::*;
#(
   parameter int p_router_id      = 0,
   parameter int p_num_routers    = 8,
   parameter int p_num_free_nbits = 2,
   parameter int c_dest_nbits     = $clog2(p_num_routers)
)(
   input  logic [c_dest_nbits-1:0]     dest,
   input  logic [p_num_free_nbits-1:0] num_free_west,
   input  logic [p_num_free_nbits-1:0] num_free_east,
   output logic [2:0]                  route
);

   localparam int c_dw = c_dest_nbits + 1;
   localparam logic [c_dw-1:0] c_id   = c_dw'(p_router_id);
   localparam logic [c_dw-1:0] c_wrap = c_dw'(p_num_routers - p_router_id);
   localparam logic [c_dw-1:0] c_half = c_dw'(p_num_routers / 2);

   logic [c_dw-1:0] dest_s;
   logic [c_dw-1:0] dist_s;
   logic            east_ok_s;
   logic            west_ok_s;

   // Eastward ring distance, then direction choice with credit gating.
   always_comb begin
      dest_s    = {1'b0, dest};
      dist_s    = {c_dw{1'b0}};
      east_ok_s = int'(num_free_east) >= BUBBLE_CREDIT;
      west_ok_s = int'(num_free_west) >= BUBBLE_CREDIT;
      route     = 3'b000;
      if (dest_s >= c_id) begin
         dist_s = dest_s - c_id;
      end else begin
         dist_s = dest_s + c_wrap;
      end
      if (dist_s == {c_dw{1'b0}}) begin
         route[REQ_TERM] = 1'b1;
      end else if (dist_s <= c_half) begin
         route[REQ_EAST] = east_ok_s;
      end else begin
         route[REQ_WEST] = west_ok_s;
      end
   end

endmodule

// File: rtl/plab4_net_router_input_terminal_arbiter_tdm.sv
// TDM input-terminal arbiter: only the slot owner may request; last slot cycle is dead.
// Optional build macro PLAB4_NET_ARB_WORK_CONSERVING_EN skips idle owners and drops the dead cycle.
module plab4_net_router_input_terminal_arbiter_tdm
   import plab4_net_arb_pkg::*;
#(
   parameter int p_router_id      = 0,
   parameter int p_num_routers    = 8,
   parameter int p_num_free_nbits = 2,
   parameter int p_num_domains    = 2,
   parameter int p_slot_len       = 4,
   parameter int c_dest_nbits     = $clog2(p_num_routers),
   parameter int c_dom_nbits      = dom_nbits(p_num_domains),
   parameter int c_slot_nbits     = $clog2(p_slot_len)
)(
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [p_num_domains*c_dest_nbits-1:0]     dest,
   input  logic [p_num_domains-1:0]              in_val,
   output logic [p_num_domains-1:0]              in_rdy,
   input  logic [p_num_domains*p_num_free_nbits-1:0] num_free_west,
   input  logic [p_num_domains*p_num_free_nbits-1:0] num_free_east,
   output logic [2:0]                            reqs,
   input  logic [2:0]                            grants,
   output logic [c_dom_nbits-1:0]                cur_domain,
   output logic [c_slot_nbits-1:0]               slot_cnt
);

   logic [2:0]               route_s [p_num_domains];
   logic [p_num_domains-1:0] owner_sel_s;
   logic [2:0]               owner_route_s;
   logic                     owner_val_s;
   logic                     last_s;
   logic                     open_s;
   logic                     xfer_s;
   logic [c_dom_nbits-1:0]   cur_domain_r;
   logic [c_slot_nbits-1:0]  slot_cnt_r;
   logic [c_dom_nbits-1:0]   dom_nxt_s;
   logic [c_slot_nbits-1:0]  slot_nxt_s;

   for (genvar d = 0; d < p_num_domains; d++) begin : g_route
      plab4_net_route_compute #(
         .p_router_id      (p_router_id),
         .p_num_routers    (p_num_routers),
         .p_num_free_nbits (p_num_free_nbits),
         .c_dest_nbits     (c_dest_nbits)
      ) u_route (
         .dest          (dest[d*c_dest_nbits +: c_dest_nbits]),
         .num_free_west (num_free_west[d*p_num_free_nbits +: p_num_free_nbits]),
         .num_free_east (num_free_east[d*p_num_free_nbits +: p_num_free_nbits]),
         .route         (route_s[d])
      );
   end

   // Owner selection by AND-OR masking so non-owner inputs never reach the output.
   always_comb begin
      owner_route_s = 3'b000;
      owner_val_s   = 1'b0;
      for (int d = 0; d < p_num_domains; d++) begin
         owner_sel_s[d] = (cur_domain_r == c_dom_nbits'(d));
         owner_route_s  = owner_route_s | (route_s[d] & {3{owner_sel_s[d]}});
         owner_val_s    = owner_val_s | (in_val[d] & owner_sel_s[d]);
      end
   end

   assign last_s = (slot_cnt_r == c_slot_nbits'(p_slot_len - 1));
`ifdef PLAB4_NET_ARB_WORK_CONSERVING_EN
   assign open_s = 1'b1;
`else
   assign open_s = ~last_s;
`endif

   // Requests and dequeue; reset is folded in so outputs are quiet while it is held.
   always_comb begin
      reqs = 3'b000;
      if (reset && owner_val_s && open_s) begin
         reqs = owner_route_s;
      end else begin
         reqs = 3'b000;
      end
      xfer_s = |(reqs & grants);
      in_rdy = owner_sel_s & {p_num_domains{xfer_s}};
   end

`ifdef PLAB4_NET_ARB_WORK_CONSERVING_EN
   logic                   skip_found_s;
   logic [c_dom_nbits-1:0] skip_dom_s;

   // Round-robin search from owner+1; descending scan so the nearest hit wins.
   always_comb begin
      skip_found_s = 1'b0;
      skip_dom_s   = cur_domain_r;
      for (int k = p_num_domains - 1; k >= 1; k--) begin
         if (in_val[(int'(cur_domain_r) + k) % p_num_domains]) begin
            skip_found_s = 1'b1;
            skip_dom_s   = c_dom_nbits'((int'(cur_domain_r) + k) % p_num_domains);
         end else begin
            skip_found_s = skip_found_s;
         end
      end
   end
`endif

   // Fixed slot schedule: count within the slot, hand over at the last cycle.
   always_comb begin
      slot_nxt_s = slot_cnt_r;
      dom_nxt_s  = cur_domain_r;
      if (last_s) begin
         slot_nxt_s = {c_slot_nbits{1'b0}};
         if (cur_domain_r == c_dom_nbits'(p_num_domains - 1)) begin
            dom_nxt_s = {c_dom_nbits{1'b0}};
         end else begin
            dom_nxt_s = cur_domain_r + c_dom_nbits'(1);
         end
      end else begin
         slot_nxt_s = slot_cnt_r + c_slot_nbits'(1);
      end
`ifdef PLAB4_NET_ARB_WORK_CONSERVING_EN
      if ((slot_cnt_r == {c_slot_nbits{1'b0}}) && !owner_val_s && skip_found_s) begin
         dom_nxt_s  = skip_dom_s;
         slot_nxt_s = {c_slot_nbits{1'b0}};
      end else begin
         dom_nxt_s  = dom_nxt_s;
      end
`endif
   end

   // Slot owner and position registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_domain_r <= {c_dom_nbits{1'b0}};
         slot_cnt_r   <= {c_slot_nbits{1'b0}};
      end else begin
         cur_domain_r <= dom_nxt_s;
         slot_cnt_r   <= slot_nxt_s;
      end
   end

   assign cur_domain = cur_domain_r;
   assign slot_cnt   = slot_cnt_r;

endmodule

// File: tb/tb_plab4_net_router_input_terminal_arbiter_tdm.sv
// Directed bench for the TDM arbiter: 4 domains, 4-cycle slots, router 0 of 8.
module tb_plab4_net_router_input_terminal_arbiter_tdm;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] dest;
   logic [3:0]  in_val;
   logic [3:0]  in_rdy;
   logic [7:0]  nfw;
   logic [7:0]  nfe;
   logic [2:0]  reqs;
   logic [2:0]  grants;
   logic [1:0]  cur_domain;
   logic [1:0]  slot_cnt;

   int checks = 0;
   int errors = 0;
   int k = 0;
   int n;
   int trace1 [32];
   logic [31:0] pat;

   typedef struct {
      int          dom;
      int          slot;
      logic [11:0] dest;
      logic [3:0]  val;
      logic [7:0]  nfw;
      logic [7:0]  nfe;
      logic [2:0]  gr;
      logic [2:0]  ereq;
      logic [3:0]  erdy;
   } vec_t;
   vec_t vt [14];

   always #5 clk = ~clk;

   plab4_net_router_input_terminal_arbiter_tdm #(
      .p_router_id      (0),
      .p_num_routers    (8),
      .p_num_free_nbits (2),
      .p_num_domains    (4),
      .p_slot_len       (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .dest          (dest),
      .in_val        (in_val),
      .in_rdy        (in_rdy),
      .num_free_west (nfw),
      .num_free_east (nfe),
      .reqs          (reqs),
      .grants        (grants),
      .cur_domain    (cur_domain),
      .slot_cnt      (slot_cnt)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, k);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      k++;
      #1;
   endtask

   task automatic chk_state();
      check("cur_domain", int'(cur_domain), (k / 4) % 4);
      check("slot_cnt", int'(slot_cnt), k % 4);
   endtask

   task automatic goto_pos(input int d, input int s);
      int cnt;
      cnt = 1;
      tick();
      while (!(((k / 4) % 4 == d) && (k % 4 == s)) && cnt < 40) begin
         tick();
         cnt++;
      end
      if (cnt >= 40) check("goto_timeout", cnt, 0);
   endtask

   task automatic run_ni(input int noisy);
      int e;
      for (int j = 0; j < 32; j++) begin
         in_val[0] = pat[j];
         dest[2:0] = 3'd0;
         grants    = 3'b010;
         if (noisy != 0) begin
            in_val[3:1] = 3'($urandom);
            dest[11:3]  = 9'($urandom);
            nfw         = {6'($urandom), 2'b00};
            nfe         = {6'($urandom), 2'b00};
         end else begin
            in_val[3:1] = 3'd0;
            dest[11:3]  = 9'd0;
            nfw         = 8'h00;
            nfe         = 8'h00;
         end
         #2;
         e = (((j / 4) % 4 == 0) && (j % 4 != 3)) ? int'(pat[j]) : 0;
         check("ni_model", int'(in_rdy[0]), e);
         if (noisy == 0) trace1[j] = int'(in_rdy[0]);
         else check("ni_trace", int'(in_rdy[0]), trace1[j]);
         tick();
      end
   endtask

   initial begin
      vt[0]  = '{0, 1, 12'h000, 4'b0001, 8'h00, 8'h00, 3'b010, 3'b010, 4'b0001};
      vt[1]  = '{0, 2, 12'h000, 4'b0001, 8'h00, 8'h00, 3'b000, 3'b010, 4'b0000};
      vt[2]  = '{1, 0, 12'h018, 4'b0010, 8'h00, 8'h04, 3'b100, 3'b000, 4'b0000};
      vt[3]  = '{1, 1, 12'h018, 4'b0010, 8'h00, 8'h08, 3'b100, 3'b100, 4'b0010};
      vt[4]  = '{1, 2, 12'h018, 4'b0010, 8'h00, 8'h08, 3'b001, 3'b100, 4'b0000};
      vt[5]  = '{2, 0, 12'h180, 4'b0100, 8'h20, 8'h00, 3'b001, 3'b001, 4'b0100};
      vt[6]  = '{2, 1, 12'h180, 4'b0100, 8'h10, 8'h00, 3'b001, 3'b000, 4'b0000};
      vt[7]  = '{2, 2, 12'h100, 4'b0100, 8'h00, 8'h30, 3'b100, 3'b100, 4'b0100};
      vt[8]  = '{2, 3, 12'h100, 4'b0100, 8'h00, 8'h30, 3'b100, 3'b000, 4'b0000};
      vt[9]  = '{3, 0, 12'hA00, 4'b0111, 8'hC0, 8'h00, 3'b001, 3'b000, 4'b0000};
      vt[10] = '{3, 1, 12'hE00, 4'b1000, 8'h80, 8'h00, 3'b000, 3'b001, 4'b0000};
      vt[11] = '{0, 0, 12'h003, 4'b1111, 8'hFF, 8'hFE, 3'b100, 3'b100, 4'b0001};
      vt[12] = '{0, 2, 12'h001, 4'b0001, 8'h00, 8'h02, 3'b010, 3'b100, 4'b0000};
      vt[13] = '{1, 2, 12'h000, 4'b0010, 8'h00, 8'h00, 3'b010, 3'b010, 4'b0010};
      pat = 32'hB5E3_9A4D;

      // Held in reset with a would-be terminal request present.
      reset  = 1'b0;
      dest   = 12'h000;
      in_val = 4'b0001;
      nfw    = 8'h00;
      nfe    = 8'h00;
      grants = 3'b010;
      #2;
      check("rst_reqs", int'(reqs), 0);
      check("rst_in_rdy", int'(in_rdy), 0);
      check("rst_cur_domain", int'(cur_domain), 0);
      check("rst_slot_cnt", int'(slot_cnt), 0);

      #20;
      in_val = 4'b0000;
      grants = 3'b000;
      reset  = 1'b1;
      k      = 0;
      #1;
      chk_state();
      check("idle_reqs", int'(reqs), 0);

      // Idle schedule, including the 3 -> 0 wrap after cycle 15.
      for (int i = 0; i < 20; i++) begin
         tick();
         #2;
         chk_state();
         check("idle_reqs", int'(reqs), 0);
         check("idle_in_rdy", int'(in_rdy), 0);
      end

      for (int i = 0; i < 14; i++) begin
         goto_pos(vt[i].dom, vt[i].slot);
         dest   = vt[i].dest;
         in_val = vt[i].val;
         nfw    = vt[i].nfw;
         nfe    = vt[i].nfe;
         grants = vt[i].gr;
         #2;
         chk_state();
         check($sformatf("vec%0d_reqs", i), int'(reqs), int'(vt[i].ereq));
         check($sformatf("vec%0d_in_rdy", i), int'(in_rdy), int'(vt[i].erdy));
      end

      // Domain 0 becomes valid on its dead cycle: served at its next slot.
      goto_pos(0, 3);
      dest   = 12'h000;
      in_val = 4'b0001;
      nfw    = 8'h00;
      nfe    = 8'h00;
      grants = 3'b010;
      #2;
      check("dead_reqs", int'(reqs), 0);
      check("dead_in_rdy", int'(in_rdy), 0);
      n = 0;
      while (in_rdy[0] == 1'b0 && n < 20) begin
         tick();
         n++;
         #2;
      end
      check("dead_wait", n, 13);
      check("dead_resume_reqs", int'(reqs), 2);
      check("dead_resume_dom", int'(cur_domain), 0);

      // Non-interference: quiet vs noisy non-owner domains.
      goto_pos(0, 0);
      run_ni(0);
      goto_pos(0, 0);
      run_ni(1);

      // Asynchronous reset mid-slot.
      goto_pos(2, 2);
      dest   = 12'h000;
      in_val = 4'b0100;
      nfw    = 8'h00;
      nfe    = 8'h00;
      grants = 3'b010;
      #2;
      check("pre_reset_reqs", int'(reqs), 2);
      check("pre_reset_in_rdy", int'(in_rdy), 4);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_cur_domain", int'(cur_domain), 0);
      check("async_rst_slot_cnt", int'(slot_cnt), 0);
      check("async_rst_reqs", int'(reqs), 0);
      check("async_rst_in_rdy", int'(in_rdy), 0);
      @(negedge clk);
      reset = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
